// File: rtl/spi_xfer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_xfer_ctrl_if
// Purpose  : host command/FIFO port and byte-engine port of spi_xfer_ctrl
// Revision : 1.0
// ============================================================================
interface spi_xfer_ctrl_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  cmd_start;
    logic                  cmd_abort;
    logic [DEPTH_LOG2:0]   cmd_len;
    logic [7:0]            cs_sel;
    logic                  tx_wr;
    logic [7:0]            tx_data;
    logic                  rx_rd;
    logic [7:0]            rx_data;
    logic                  tx_full;
    logic                  rx_empty;
    logic [DEPTH_LOG2:0]   rx_count;
    logic                  busy;
    logic                  done;
    logic                  underrun;
    logic                  overrun;
    logic                  aborted;
    logic                  spi_start;
    logic [7:0]            spi_data_in;
    logic [7:0]            spi_data_out;
    logic                  spi_new_data;
    logic                  spi_busy;
    logic [7:0]            spi_cs_n;

    // slave is the sequencer's view; master is the host plus byte engine
    modport slave (
        input  cmd_start, cmd_abort, cmd_len, cs_sel, tx_wr, tx_data, rx_rd,
               spi_data_out, spi_new_data, spi_busy,
        output rx_data, tx_full, rx_empty, rx_count, busy, done, underrun,
               overrun, aborted, spi_start, spi_data_in, spi_cs_n
    );

    modport master (
        output cmd_start, cmd_abort, cmd_len, cs_sel, tx_wr, tx_data, rx_rd,
               spi_data_out, spi_new_data, spi_busy,
        input  rx_data, tx_full, rx_empty, rx_count, busy, done, underrun,
               overrun, aborted, spi_start, spi_data_in, spi_cs_n
    );
endinterface
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_xfer_ctrl
// Purpose  : multi-byte SPI transfer sequencer with TX/RX byte FIFOs
// Revision : 1.0
// ============================================================================
module spi_xfer_ctrl #(
    parameter int DEPTH_LOG2 = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int CS_IDLE    = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    spi_xfer_ctrl_if.slave     bus
);
    localparam int                  c_DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL      = (DEPTH_LOG2+1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0] c_ONE       = (DEPTH_LOG2+1)'(1);
    localparam logic [7:0]          c_SETUP_END = 8'(CS_SETUP - 1);
    localparam logic [7:0]          c_HOLD_END  = 8'(CS_HOLD);
    localparam logic [7:0]          c_IDLE_END  = 8'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t                  r_state;
    logic [7:0]              r_tcnt;
    logic [DEPTH_LOG2:0]     r_len;
    logic [7:0]              r_cs_sel;
    logic [7:0]              r_cs_n;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_underrun;
    logic                    r_overrun;
    logic                    r_aborted;
    logic                    r_abort_pend;
    logic                    r_spi_start;
    logic [7:0]              r_spi_data_in;
    logic                    r_rx_pend;
    logic [7:0]              r_rx_pend_data;

    logic [7:0]              r_tx_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0]   r_tx_wp;
    logic [DEPTH_LOG2-1:0]   r_tx_rp;
    logic [DEPTH_LOG2:0]     r_tx_cnt;
    logic [7:0]              r_rx_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0]   r_rx_wp;
    logic [DEPTH_LOG2-1:0]   r_rx_rp;
    logic [DEPTH_LOG2:0]     r_rx_cnt;

    logic w_tx_push;
    logic w_tx_pop;
    logic w_rx_push;
    logic w_rx_pop;
    logic w_abort;

    assign w_tx_push = bus.tx_wr && (r_tx_cnt != c_FULL);
    assign w_tx_pop  = (r_state == ST_ISSUE) && !bus.spi_busy && !r_abort_pend
                       && (r_tx_cnt != '0);
    assign w_rx_push = r_rx_pend && (r_rx_cnt != c_FULL);
    assign w_rx_pop  = bus.rx_rd && (r_rx_cnt != '0);
    assign w_abort   = bus.cmd_abort && ((r_state == ST_SETUP) ||
                       (r_state == ST_ISSUE) || (r_state == ST_WAIT));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_tcnt         <= '0;
            r_len          <= '0;
            r_cs_sel       <= '0;
            r_cs_n         <= 8'hFF;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_underrun     <= 1'b0;
            r_overrun      <= 1'b0;
            r_aborted      <= 1'b0;
            r_abort_pend   <= 1'b0;
            r_spi_start    <= 1'b0;
            r_spi_data_in  <= '0;
            r_rx_pend      <= 1'b0;
            r_rx_pend_data <= '0;
        end else begin
            r_spi_start <= 1'b0;
            r_done      <= 1'b0;
            r_rx_pend   <= 1'b0;
            if (w_abort) begin
                r_abort_pend <= 1'b1;
                r_aborted    <= 1'b1;
            end
            // Received bytes land in RX one cycle after spi_new_data
            if (r_rx_pend && (r_rx_cnt == c_FULL)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_start) begin
                        r_underrun   <= 1'b0;
                        r_overrun    <= 1'b0;
                        r_aborted    <= 1'b0;
                        r_abort_pend <= 1'b0;
                        r_len        <= bus.cmd_len;
                        r_cs_sel     <= bus.cs_sel;
                        r_tcnt       <= '0;
                        if (bus.cmd_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    r_cs_n <= ~r_cs_sel;
                    r_busy <= 1'b1;
                    if (r_abort_pend) begin
                        r_state <= ST_HOLD;
                        r_tcnt  <= '0;
                    end else if (r_tcnt == c_SETUP_END) begin
                        r_state <= ST_ISSUE;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                ST_ISSUE: begin
                    if (r_abort_pend) begin
                        r_state <= ST_HOLD;
                        r_tcnt  <= '0;
                    end else if (!bus.spi_busy) begin
                        r_spi_start <= 1'b1;
                        if (r_tx_cnt != '0) begin
                            r_spi_data_in <= r_tx_mem[r_tx_rp];
                        end else begin
                            r_spi_data_in <= 8'hFF;
                            r_underrun    <= 1'b1;
                        end
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.spi_new_data) begin
                        r_rx_pend      <= 1'b1;
                        r_rx_pend_data <= bus.spi_data_out;
                        r_len          <= r_len - c_ONE;
                        if ((r_len == c_ONE) || r_abort_pend || bus.cmd_abort) begin
                            r_state <= ST_HOLD;
                            r_tcnt  <= '0;
                        end else begin
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_tcnt == c_HOLD_END) begin
                        r_cs_n  <= 8'hFF;
                        r_done  <= 1'b1;
                        r_state <= ST_GAP;
                        r_tcnt  <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (r_tcnt == c_IDLE_END) begin
                        r_busy       <= 1'b0;
                        r_abort_pend <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.tx_data;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_pend_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + DEPTH_LOG2'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + DEPTH_LOG2'(1);
            r_tx_cnt <= r_tx_cnt + (DEPTH_LOG2+1)'(w_tx_push) - (DEPTH_LOG2+1)'(w_tx_pop);
            if (w_rx_push) r_rx_wp <= r_rx_wp + DEPTH_LOG2'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + DEPTH_LOG2'(1);
            r_rx_cnt <= r_rx_cnt + (DEPTH_LOG2+1)'(w_rx_push) - (DEPTH_LOG2+1)'(w_rx_pop);
        end
    end

    assign bus.rx_data     = r_rx_mem[r_rx_rp];
    assign bus.tx_full     = (r_tx_cnt == c_FULL);
    assign bus.rx_empty    = (r_rx_cnt == '0);
    assign bus.rx_count    = r_rx_cnt;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.underrun    = r_underrun;
    assign bus.overrun     = r_overrun;
    assign bus.aborted     = r_aborted;
    assign bus.spi_start   = r_spi_start;
    assign bus.spi_data_in = r_spi_data_in;
    assign bus.spi_cs_n    = r_cs_n;
endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_xfer_ctrl
// Purpose  : scoreboard bench for spi_xfer_ctrl with a loopback byte engine
// Revision : 1.0
// ============================================================================
module tb_spi_xfer_ctrl;
    localparam int DL      = 2;
    localparam int S       = 2;
    localparam int H       = 2;
    localparam int I       = 4;
    localparam int ENG_LAT = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;

    spi_xfer_ctrl_if #(.DEPTH_LOG2(DL)) bus ();

    spi_xfer_ctrl #(
        .DEPTH_LOG2 (DL),
        .CS_SETUP   (S),
        .CS_HOLD    (H),
        .CS_IDLE    (I)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Scoreboard queues filled by the stimulus
    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rx[$];
    logic [7:0] exp_cs = 8'hFF;

    int n_start = 0, n_done = 0, n_cs_fall = 0, n_busy_rise = 0;
    int t_busy_rise = 0, t_cs_fall = 0, t_cs_rise = 0, t_done = 0, t_busy_fall = 0, t_nd_last = 0;
    int t_starts[$];
    int nd_edges[$];
    logic       prev_busy = 1'b0;
    logic [7:0] prev_cs   = 8'hFF;
    bit rxlat_en   = 1'b0;
    int rxlat_c    = -1;
    int rxlat_base = 0;

    // Monitor samples just before each rising edge
    always @(negedge clk) begin
        #4;
        if (bus.spi_start) begin
            n_start++;
            t_starts.push_back(cyc);
            if (exp_mosi.size() == 0) fail_now($sformatf("unexpected_start data=%0h", bus.spi_data_in));
            else cmp("mosi_byte", bus.spi_data_in, exp_mosi.pop_front());
            cmp("cs_during_byte", bus.spi_cs_n, exp_cs);
        end
        if (bus.rx_rd && !bus.rx_empty) begin
            if (exp_rx.size() == 0) fail_now($sformatf("unexpected_rx_pop data=%0h", bus.rx_data));
            else cmp("rx_data", bus.rx_data, exp_rx.pop_front());
        end
        if (bus.done) begin
            n_done++;
            t_done = cyc;
        end
        if (bus.busy && !prev_busy) begin
            n_busy_rise++;
            t_busy_rise = cyc;
        end
        if (!bus.busy && prev_busy) t_busy_fall = cyc;
        if (bus.spi_cs_n != 8'hFF && prev_cs == 8'hFF) begin
            n_cs_fall++;
            t_cs_fall = cyc;
        end
        if (bus.spi_cs_n == 8'hFF && prev_cs != 8'hFF) t_cs_rise = cyc;
        if (rxlat_c >= 0) begin
            if (cyc == rxlat_c + 1) cmp("rx_count_before_push", bus.rx_count, rxlat_base);
            if (cyc == rxlat_c + 2) begin
                cmp("rx_count_after_push", bus.rx_count, rxlat_base + 1);
                rxlat_c = -1;
            end
        end
        if (bus.spi_new_data) begin
            t_nd_last = cyc + 1;
            nd_edges.push_back(cyc + 1);
            if (rxlat_en) begin
                rxlat_en   = 1'b0;
                rxlat_c    = cyc;
                rxlat_base = int'(bus.rx_count);
            end
        end
        prev_busy = bus.busy;
        prev_cs   = bus.spi_cs_n;
    end

    // Loopback byte engine: MISO returns the MOSI byte after ENG_LAT cycles
    int         eng_cnt    = 0;
    logic [7:0] eng_byte   = 8'h00;
    logic       prev_start = 1'b0;
    bit         eng_skip   = 1'b0;
    always @(negedge clk) begin
        bus.spi_new_data = 1'b0;
        if (bus.spi_start) begin
            cmp("start_while_busy", bus.spi_busy, 0);
            cmp("start_back_to_back", prev_start, 0);
        end
        prev_start = bus.spi_start;
        if (!rst && eng_cnt > 0) eng_skip = 1'b1;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                if (!eng_skip) cmp("data_in_stable", bus.spi_data_in, eng_byte);
                bus.spi_data_out = eng_byte;
                bus.spi_new_data = 1'b1;
                bus.spi_busy     = 1'b0;
            end
        end
        if (bus.spi_start) begin
            eng_byte     = bus.spi_data_in;
            eng_cnt      = ENG_LAT;
            eng_skip     = 1'b0;
            bus.spi_busy = 1'b1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] d, input bit on_wire);
        bus.tx_wr   = 1'b1;
        bus.tx_data = d;
        if (on_wire) exp_mosi.push_back(d);
        tick();
        bus.tx_wr = 1'b0;
    endtask

    task automatic pop_rx(input logic [7:0] d);
        exp_rx.push_back(d);
        bus.rx_rd = 1'b1;
        tick();
        bus.rx_rd = 1'b0;
    endtask

    task automatic start(input logic [DL:0] len, input logic [7:0] sel, output int t0);
        bus.cmd_len   = len;
        bus.cs_sel    = sel;
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int target, input int max_cyc);
        int k = 0;
        while (!(n_done >= target && !bus.busy) && k < max_cyc) begin
            tick();
            k++;
        end
        if (k >= max_cyc) fail_now("timeout_waiting_for_done");
        tick(2);
    endtask

    task automatic wait_starts(input int target, input int max_cyc);
        int k = 0;
        while (n_start < target && k < max_cyc) begin
            tick();
            k++;
        end
        if (k >= max_cyc) fail_now("timeout_waiting_for_spi_start");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, bs, bd, bc, bb, si, ni;
        bus.cmd_start = 1'b0; bus.cmd_abort = 1'b0; bus.cmd_len = '0; bus.cs_sel = '0;
        bus.tx_wr = 1'b0; bus.tx_data = '0; bus.rx_rd = 1'b0;
        bus.spi_data_out = '0; bus.spi_new_data = 1'b0; bus.spi_busy = 1'b0;
        tick(3);
        cmp("reset_cs_n", bus.spi_cs_n, 8'hFF);
        cmp("reset_busy_done_start", {bus.busy, bus.done, bus.spi_start}, 0);
        cmp("reset_flags", {bus.underrun, bus.overrun, bus.aborted}, 0);
        cmp("reset_fifo_flags", {bus.rx_empty, bus.tx_full}, 2'b10);
        cmp("reset_rx_count", bus.rx_count, 0);
        cmp("reset_spi_data_in", bus.spi_data_in, 0);
        rst = 1'b1;
        tick();

        // Basic two-byte loopback transfer with exact latencies
        exp_cs = 8'hFE;
        push_tx(8'hA5, 1); push_tx(8'h3C, 1);
        bs = n_start; bd = n_done; si = t_starts.size(); ni = nd_edges.size();
        rxlat_en = 1'b1;
        start(3'd2, 8'h01, t0);
        wait_done(bd + 1, 300);
        cmp("basic_busy_latency", t_busy_rise - t0, 1);
        cmp("basic_cs_latency", t_cs_fall - t0, 1);
        cmp("basic_start_count", n_start - bs, 2);
        cmp("basic_first_start", t_starts[si] - t0, 1 + S);
        cmp("basic_second_start", t_starts[si + 1] - nd_edges[ni], 1);
        cmp("basic_done_latency", t_done - t_nd_last, 1 + H);
        cmp("basic_cs_release", t_cs_rise - t_nd_last, 1 + H);
        cmp("basic_busy_release", t_busy_fall - t_nd_last, 1 + H + I);
        cmp("basic_done_count", n_done - bd, 1);
        cmp("basic_flags", {bus.underrun, bus.overrun, bus.aborted}, 0);
        pop_rx(8'hA5); pop_rx(8'h3C);
        cmp("basic_rx_empty", bus.rx_empty, 1);

        // Underrun: one TX byte, three bytes requested
        push_tx(8'h11, 1);
        exp_mosi.push_back(8'hFF); exp_mosi.push_back(8'hFF);
        bs = n_start; bd = n_done;
        start(3'd3, 8'h01, t0);
        wait_done(bd + 1, 400);
        cmp("underrun_flag", bus.underrun, 1);
        cmp("underrun_rx_count", bus.rx_count, 3);
        cmp("underrun_start_count", n_start - bs, 3);
        pop_rx(8'h11); pop_rx(8'hFF); pop_rx(8'hFF);

        // Zero-length command
        bs = n_start; bd = n_done; bc = n_cs_fall; bb = n_busy_rise;
        start(3'd0, 8'h01, t0);
        tick(4);
        cmp("zero_len_done_count", n_done - bd, 1);
        cmp("zero_len_done_time", t_done - t0, 0);
        cmp("zero_len_no_start", n_start - bs, 0);
        cmp("zero_len_no_cs", n_cs_fall - bc, 0);
        cmp("zero_len_no_busy", n_busy_rise - bb, 0);
        cmp("start_clears_underrun", bus.underrun, 0);

        // Fill RX with four bytes; a second cmd_start during the transfer is ignored
        exp_cs = 8'hFD;
        push_tx(8'h01, 1); push_tx(8'h02, 1); push_tx(8'h03, 1); push_tx(8'h04, 1);
        cmp("tx_full_at_depth", bus.tx_full, 1);
        bs = n_start; bd = n_done; bc = n_cs_fall;
        start(3'd4, 8'h02, t0);
        wait_starts(bs + 1, 50);
        bus.cmd_len = 3'd1; bus.cs_sel = 8'h80; bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
        wait_done(bd + 1, 400);
        cmp("ignored_start_count", n_start - bs, 4);
        cmp("ignored_done_count", n_done - bd, 1);
        cmp("ignored_cs_edges", n_cs_fall - bc, 1);
        cmp("fill_rx_count", bus.rx_count, 4);
        cmp("fill_no_overrun", bus.overrun, 0);

        // Overrun: RX already full
        exp_cs = 8'hFE;
        push_tx(8'h55, 1); push_tx(8'h66, 1);
        bd = n_done;
        start(3'd2, 8'h01, t0);
        wait_done(bd + 1, 300);
        cmp("overrun_flag", bus.overrun, 1);
        cmp("overrun_rx_count", bus.rx_count, 4);
        pop_rx(8'h01); pop_rx(8'h02); pop_rx(8'h03); pop_rx(8'h04);
        cmp("overrun_rx_empty", bus.rx_empty, 1);

        // Abort during the first byte of a four-byte transfer
        push_tx(8'h71, 1); push_tx(8'h72, 0); push_tx(8'h73, 0); push_tx(8'h74, 0);
        bs = n_start; bd = n_done;
        start(3'd4, 8'h01, t0);
        wait_starts(bs + 1, 50);
        tick(2);
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        wait_done(bd + 1, 300);
        cmp("abort_start_count", n_start - bs, 1);
        cmp("abort_flag", bus.aborted, 1);
        cmp("abort_done_count", n_done - bd, 1);
        cmp("abort_cs_release", t_cs_rise - t_nd_last, 1 + H);
        cmp("abort_rx_count", bus.rx_count, 1);
        pop_rx(8'h71);

        // Reset during the second byte, then a clean one-byte transfer
        exp_mosi.push_back(8'h72); exp_mosi.push_back(8'h73);
        bs = n_start;
        start(3'd2, 8'h01, t0);
        wait_starts(bs + 2, 100);
        tick(2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        cmp("midreset_cs_n", bus.spi_cs_n, 8'hFF);
        cmp("midreset_busy", bus.busy, 0);
        cmp("midreset_rx", {bus.rx_empty, bus.rx_count}, {1'b1, 3'd0});
        cmp("midreset_tx_full", bus.tx_full, 0);
        tick();
        push_tx(8'h9A, 1);
        bs = n_start; bd = n_done;
        start(3'd1, 8'h01, t0);
        wait_done(bd + 1, 300);
        cmp("post_reset_start_count", n_start - bs, 1);
        cmp("post_reset_flags", {bus.underrun, bus.overrun, bus.aborted}, 0);
        pop_rx(8'h9A);
        cmp("mosi_queue_drained", exp_mosi.size(), 0);
        cmp("rx_queue_drained", exp_rx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
